// File: rtl/usr_pkg.sv
// usr_pkg: shared op, select and state codes for the USR command sequencer
package usr_pkg;
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/usr_shift_counter.sv
// usr_shift_counter: loadable down-counter flagging its final shift cycle
module usr_shift_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] din,
  output logic             last
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= din;
    else if (dec) cnt <= cnt - 1'b1;
  end
  assign last = cnt == CNT_W'(1);
endmodule

// File: rtl/usr_ctrl.sv
// usr_ctrl: sequences hold/shift/load commands onto the USR slice control lines
module usr_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  output logic [1:0]       usr_select,
  output logic [WIDTH-1:0] usr_pdata,
  output logic             usr_sin_left,
  output logic             usr_sin_right,
  input  logic [WIDTH-1:0] usr_q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  logic [1:0]       state, nxt, op;
  logic [WIDTH-1:0] data;
  logic             fill, last, accept;
  assign accept = cmd_valid & cmd_ready;
  usr_shift_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .load(accept),
    .dec (state == ST_SHIFT),
    .din (cmd_count),
    .last(last)
  );
  always_comb begin
    nxt = state == ST_IDLE  ? (!cmd_valid ? ST_IDLE :
                               cmd_op == OP_LOAD ? ST_LOAD :
                               (cmd_op == OP_HOLD || cmd_count == '0) ? ST_DONE : ST_SHIFT) :
          state == ST_LOAD  ? ST_DONE :
          state == ST_SHIFT ? (last ? ST_DONE : ST_SHIFT) : ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      op     <= OP_HOLD;
      data   <= '0;
      fill   <= 1'b0;
      result <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        op   <= cmd_op;
        data <= cmd_data;
        fill <= cmd_fill;
      end
      if (state == ST_DONE) result <= usr_q;
    end
  end
  // Everything below decodes from state and latched fields only, never from cmd_*
  assign cmd_ready     = state == ST_IDLE;
  assign busy          = state != ST_IDLE;
  assign done          = state == ST_DONE;
  assign usr_select    = state == ST_LOAD ? SEL_LOAD :
                         state == ST_SHIFT ? (op == OP_SHR ? SEL_SHR : SEL_SHL) : SEL_HOLD;
  assign usr_pdata     = state == ST_LOAD ? data : '0;
  assign usr_sin_left  = state == ST_SHIFT && fill;
  assign usr_sin_right = state == ST_SHIFT && fill;
endmodule

// File: doc/usr_ctrl.md
Name: usr_ctrl

Overview:
Command sequencer that drives the control side of the universal shift register (USR) bit-slice array. It accepts hold, shift-right, shift-left and load commands over a valid/ready handshake. It generates the per-cycle 2-bit select code, parallel data and serial fill bits the slice muxes consume, counts shift cycles, and reports completion with a captured register snapshot.

Parameters:
WIDTH, 4, USR bit count (number of slices driven).
CNT_W, 3, width of shift-count field; max shifts per command = 2^CNT_W-1.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept command
cmd_op  in  2  00 HOLD, 01 SHR, 10 SHL, 11 LOAD
cmd_count  in  CNT_W  shift cycles for SHR/SHL; ignored otherwise
cmd_data  in  WIDTH  parallel value for LOAD
cmd_fill  in  1  serial bit shifted in during SHR/SHL
usr_select  out  2  to slice select: 00 hold, 01 shift-right, 10 shift-left, 11 parallel load
usr_pdata  out  WIDTH  to slice d_parallel_load inputs
usr_sin_left  out  1  serial input at left end of array
usr_sin_right  out  1  serial input at right end of array
usr_q  in  WIDTH  current USR register contents
busy  out  1  command in progress (state != IDLE)
done  out  1  one-cycle completion pulse
result  out  WIDTH  usr_q captured at completion; held until next completion

Behaviour:
- Reset values (next edge with rst=1): state IDLE, cmd_ready=1, busy=0, done=0, usr_select=00, usr_pdata=0, usr_sin_left=usr_sin_right=0, result=0.
- Reset mid-command aborts it. No done pulse. Outputs return to reset values after that edge.
- States: IDLE, LOAD, SHIFT, DONE. All outputs are registered or decoded purely from state and latched fields. There is no combinational path from cmd_* to usr_*.
- IDLE:
  - cmd_ready=1, usr_select=00.
  - Accept on cmd_valid&cmd_ready: latch op, count, data, fill.
  - HOLD -> DONE. LOAD -> LOAD. SHR/SHL with count=0 -> DONE. SHR/SHL with count>0 -> SHIFT; load down-counter with count.
- LOAD: exactly one cycle, usr_select=11, usr_pdata=latched data -> DONE.
- SHIFT:
  - usr_select=01 (SHR) or 10 (SHL).
  - usr_sin_left=usr_sin_right=latched fill.
  - Counter decrements each cycle. When counter==1 -> DONE, so exactly count shift cycles.
- DONE:
  - One cycle, usr_select=00, done=1.
  - result <= usr_q on this cycle's edge (usr_q already reflects the final USR edge). Next state IDLE.
- cmd_ready is 1 only in IDLE. cmd_valid in other states is ignored; the producer holds valid/op/data stable until accepted.
- Minimum one IDLE cycle between commands.
- Latency from accept edge E:
  - LOAD: select=11 in cycle E+1, done in E+2.
  - SHR/SHL of N>0: select shift in E+1..E+N, done in E+N+1.
  - HOLD or count=0: done in E+1.
- usr_pdata is driven only in LOAD and is 0 otherwise. Serial outputs equal fill only in SHIFT and are 0 otherwise.
- Counter is CNT_W bits with no wrap: count=2^CNT_W-1 gives exactly that many shift cycles.
- Bench USR reference model per edge (WIDTH=4):
  - 00: q<=q
  - 01: q<={sin_left,q[3:1]}
  - 10: q<={q[2:0],sin_right}
  - 11: q<=pdata

Decomposition:
- Shared package usr_pkg:
  - op codes OP_HOLD/OP_SHR/OP_SHL/OP_LOAD.
  - select codes SEL_HOLD=00, SEL_SHR=01, SEL_SHL=10, SEL_LOAD=11, matching the slice mux encoding.
  - state enum.
- Optional sub-module usr_shift_counter: loadable down-counter with a "last" flag.
- Top-level bench instantiates usr_ctrl with the existing USR slices.

Test Plan:
- Reset: hold rst 2 cycles -> cmd_ready=1, busy=0, done=0, usr_select=00, result=0000.
- LOAD 1011 -> usr_select=11 and usr_pdata=1011 for one cycle, done one cycle later, result=1011.
- From 1011, SHR count=2 fill=0 -> usr_select=01 for exactly 2 cycles, done next, result=0010. Then SHL count=3 fill=1 -> usr_select=10 for 3 cycles, result=0111.
- SHL count=0 and HOLD -> done one cycle after accept, no shift cycles, result unchanged.
- cmd_valid held high with a new op during SHIFT -> not accepted until IDLE; accepted exactly once.
- Assert rst during cycle 2 of a count=5 SHR -> no done pulse, usr_select=00 and busy=0 after the reset edge, next LOAD works normally.
